// File: rtl/mor1kx_rf_ctrl_pkg.sv
// rtl/mor1kx_rf_ctrl_pkg.sv - state encoding and debug request layout for the GPR access sequencer
package mor1kx_rf_ctrl_pkg;

  typedef enum logic [4:0] {
    ST_CLEAR     = 5'b00001,
    ST_IDLE      = 5'b00010,
    ST_DBG_STALL = 5'b00100,
    ST_DBG_ACC   = 5'b01000,
    ST_DBG_CAP   = 5'b10000
  } rf_ctrl_state_e;

  // Captured debug request: {dat, adr, we} with we in bit 0.
  localparam int DBG_REQ_WE_BIT  = 0;
  localparam int DBG_REQ_ADR_LSB = 1;

  function automatic int dbg_req_dat_lsb(input int adr_width);
    return DBG_REQ_ADR_LSB + adr_width;
  endfunction

  function automatic int dbg_req_width(input int adr_width, input int dat_width);
    return dbg_req_dat_lsb(adr_width) + dat_width;
  endfunction

endpackage

// File: rtl/mor1kx_rf_access_ctrl.sv
// rtl/mor1kx_rf_access_ctrl.sv - GPR RAM port-A sequencer: clear after reset, debug/pipeline arbitration
module mor1kx_rf_access_ctrl
  import mor1kx_rf_ctrl_pkg::*;
#(
  parameter int OPTION_RF_ADDR_WIDTH     = 5,
  parameter int OPTION_RF_WORDS          = 32,
  parameter int OPTION_OPERAND_WIDTH     = 32,
  parameter int OPTION_RF_CLEAR_ON_RESET = 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            pipe_we_i,
  input  logic [OPTION_RF_ADDR_WIDTH-1:0] pipe_wradr_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0] pipe_wrdat_i,
  input  logic                            pipe_rden_i,
  input  logic [OPTION_RF_ADDR_WIDTH-1:0] pipe_rdad_i,
  output logic                            pipe_stall_o,
  output logic                            pipe_drop_o,
  input  logic                            dbg_req_i,
  input  logic                            dbg_we_i,
  input  logic [OPTION_RF_ADDR_WIDTH-1:0] dbg_adr_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0] dbg_dat_i,
  output logic                            dbg_ack_o,
  output logic [OPTION_OPERAND_WIDTH-1:0] dbg_dat_o,
  output logic                            rf_wren_o,
  output logic [OPTION_RF_ADDR_WIDTH-1:0] rf_wrad_o,
  output logic [OPTION_OPERAND_WIDTH-1:0] rf_wrda_o,
  output logic                            rf_rden_o,
  output logic [OPTION_RF_ADDR_WIDTH-1:0] rf_rdad_o,
  input  logic [OPTION_OPERAND_WIDTH-1:0] rf_rdda_i,
  output logic                            init_done_o
);

  localparam int AW      = OPTION_RF_ADDR_WIDTH;
  localparam int DW      = OPTION_OPERAND_WIDTH;
  localparam int REQ_W   = dbg_req_width(AW, DW);
  localparam int DAT_LSB = dbg_req_dat_lsb(AW);
  localparam logic [AW-1:0] CLR_LAST = AW'(OPTION_RF_WORDS - 1);
  localparam rf_ctrl_state_e RESET_STATE =
    (OPTION_RF_CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;

  rf_ctrl_state_e   state_q, state_d;
  logic [AW-1:0]    clr_cnt_q, clr_cnt_d;
  logic             pipe_drop_q, pipe_drop_d;
  logic             dbg_ack_q, dbg_ack_d;
  logic [DW-1:0]    dbg_dat_q, dbg_dat_d;
  logic [REQ_W-1:0] dbg_req_q, dbg_req_d;

  logic          req_we;
  logic [AW-1:0] req_adr;
  logic [DW-1:0] req_dat;

  assign req_we  = dbg_req_q[DBG_REQ_WE_BIT];
  assign req_adr = dbg_req_q[DBG_REQ_ADR_LSB +: AW];
  assign req_dat = dbg_req_q[DAT_LSB +: DW];

  logic          stall;
  logic          wren;
  logic [AW-1:0] wrad;
  logic [DW-1:0] wrda;
  logic          rden;
  logic [AW-1:0] rdad;
  logic          init_done;

  always_comb begin
    state_d     = state_q;
    clr_cnt_d   = clr_cnt_q;
    pipe_drop_d = pipe_drop_q;
    dbg_ack_d   = 1'b0;
    dbg_dat_d   = dbg_dat_q;
    dbg_req_d   = dbg_req_q;
    stall       = 1'b1;
    wren        = 1'b0;
    wrad        = '0;
    wrda        = '0;
    rden        = 1'b0;
    rdad        = '0;
    init_done   = 1'b1;

    case (state_q)
      ST_CLEAR: begin
        wren      = 1'b1;
        wrad      = clr_cnt_q;
        init_done = 1'b0;
        if (pipe_we_i) pipe_drop_d = 1'b1;
        if (clr_cnt_q == CLR_LAST) begin
          state_d = ST_IDLE;
        end else begin
          clr_cnt_d = clr_cnt_q + AW'(1);
        end
      end

      ST_IDLE: begin
        stall = 1'b0;
        wren  = pipe_we_i;
        wrad  = pipe_wradr_i;
        wrda  = pipe_wrdat_i;
        rden  = pipe_rden_i;
        rdad  = pipe_rdad_i;
        // The ack cycle ignores a still-held request so one request yields one access.
        if (dbg_req_i && !dbg_ack_q) begin
          dbg_req_d[DBG_REQ_WE_BIT]          = dbg_we_i;
          dbg_req_d[DBG_REQ_ADR_LSB +: AW]   = dbg_adr_i;
          dbg_req_d[DAT_LSB +: DW]           = dbg_dat_i;
          state_d                            = ST_DBG_STALL;
        end
      end

      ST_DBG_STALL: begin
        wren    = pipe_we_i;
        wrad    = pipe_wradr_i;
        wrda    = pipe_wrdat_i;
        rden    = pipe_rden_i;
        rdad    = pipe_rdad_i;
        state_d = ST_DBG_ACC;
      end

      ST_DBG_ACC: begin
        if (req_we) begin
          wren = 1'b1;
          wrad = req_adr;
          wrda = req_dat;
        end else begin
          rden = 1'b1;
          rdad = req_adr;
        end
        if (pipe_we_i) pipe_drop_d = 1'b1;
        state_d = ST_DBG_CAP;
      end

      ST_DBG_CAP: begin
        if (!req_we) dbg_dat_d = rf_rdda_i;
        dbg_ack_d = 1'b1;
        state_d   = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    pipe_stall_o = stall;
    rf_wren_o    = wren;
    rf_wrad_o    = wrad;
    rf_wrda_o    = wrda;
    rf_rden_o    = rden;
    rf_rdad_o    = rdad;
    init_done_o  = init_done;
    pipe_drop_o  = pipe_drop_q;
    dbg_ack_o    = dbg_ack_q;
    dbg_dat_o    = dbg_dat_q;
    if (rst) begin
      pipe_stall_o = 1'b1;
      rf_wren_o    = 1'b0;
      rf_wrad_o    = '0;
      rf_wrda_o    = '0;
      rf_rden_o    = 1'b0;
      rf_rdad_o    = '0;
      init_done_o  = 1'b0;
      pipe_drop_o  = 1'b0;
      dbg_ack_o    = 1'b0;
      dbg_dat_o    = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RESET_STATE;
      clr_cnt_q   <= '0;
      pipe_drop_q <= 1'b0;
      dbg_ack_q   <= 1'b0;
      dbg_dat_q   <= '0;
    end else begin
      state_q     <= state_d;
      clr_cnt_q   <= clr_cnt_d;
      pipe_drop_q <= pipe_drop_d;
      dbg_ack_q   <= dbg_ack_d;
      dbg_dat_q   <= dbg_dat_d;
    end
  end

  always_ff @(posedge clk) begin
    dbg_req_q <= dbg_req_d;
  end

endmodule

// File: tb/tb_mor1kx_rf_access_ctrl.sv
// tb/tb_mor1kx_rf_access_ctrl.sv - directed and randomized bench for mor1kx_rf_access_ctrl
module tb_mor1kx_rf_access_ctrl;

  localparam int AW    = 5;
  localparam int DW    = 32;
  localparam int WORDS = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          pipe_we_i;
  logic [AW-1:0] pipe_wradr_i;
  logic [DW-1:0] pipe_wrdat_i;
  logic          pipe_rden_i;
  logic [AW-1:0] pipe_rdad_i;
  logic          pipe_stall_o;
  logic          pipe_drop_o;
  logic          dbg_req_i;
  logic          dbg_we_i;
  logic [AW-1:0] dbg_adr_i;
  logic [DW-1:0] dbg_dat_i;
  logic          dbg_ack_o;
  logic [DW-1:0] dbg_dat_o;
  logic          rf_wren_o;
  logic [AW-1:0] rf_wrad_o;
  logic [DW-1:0] rf_wrda_o;
  logic          rf_rden_o;
  logic [AW-1:0] rf_rdad_o;
  logic [DW-1:0] rf_rdda_i;
  logic          init_done_o;

  logic [DW-1:0] mem    [WORDS];
  logic [DW-1:0] shadow [WORDS];
  logic          exp_drop;
  logic [DW-1:0] exp_dbg_dat;
  logic [DW-1:0] hold_dat;
  int            checks   = 0;
  int            failures = 0;

  mor1kx_rf_access_ctrl #(
    .OPTION_RF_ADDR_WIDTH    (AW),
    .OPTION_RF_WORDS         (WORDS),
    .OPTION_OPERAND_WIDTH    (DW),
    .OPTION_RF_CLEAR_ON_RESET(1)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .pipe_we_i   (pipe_we_i),
    .pipe_wradr_i(pipe_wradr_i),
    .pipe_wrdat_i(pipe_wrdat_i),
    .pipe_rden_i (pipe_rden_i),
    .pipe_rdad_i (pipe_rdad_i),
    .pipe_stall_o(pipe_stall_o),
    .pipe_drop_o (pipe_drop_o),
    .dbg_req_i   (dbg_req_i),
    .dbg_we_i    (dbg_we_i),
    .dbg_adr_i   (dbg_adr_i),
    .dbg_dat_i   (dbg_dat_i),
    .dbg_ack_o   (dbg_ack_o),
    .dbg_dat_o   (dbg_dat_o),
    .rf_wren_o   (rf_wren_o),
    .rf_wrad_o   (rf_wrad_o),
    .rf_wrda_o   (rf_wrda_o),
    .rf_rden_o   (rf_rden_o),
    .rf_rdad_o   (rf_rdad_o),
    .rf_rdda_i   (rf_rdda_i),
    .init_done_o (init_done_o)
  );

  always #5 clk = ~clk;

  // Block RAM with one-cycle read latency.
  always @(posedge clk) begin
    if (rf_wren_o) mem[rf_wrad_o] <= rf_wrda_o;
    if (rf_rden_o) rf_rdda_i <= mem[rf_rdad_o];
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    pipe_we_i    = 1'b0;
    pipe_wradr_i = '0;
    pipe_wrdat_i = '0;
    pipe_rden_i  = 1'b0;
    pipe_rdad_i  = '0;
    dbg_req_i    = 1'b0;
    dbg_we_i     = 1'b0;
    dbg_adr_i    = '0;
    dbg_dat_i    = '0;
  endtask

  task automatic do_clear(input logic hold, input logic hwe, input logic [AW-1:0] hadr,
                          input logic [DW-1:0] hdat, input logic noise);
    for (int i = 0; i < WORDS; i++) begin
      @(negedge clk);
      rst          = 1'b0;
      dbg_req_i    = hold;
      dbg_we_i     = hwe;
      dbg_adr_i    = hadr;
      dbg_dat_i    = hdat;
      pipe_we_i    = noise && (i == 5 || $urandom_range(0, 3) == 0);
      pipe_wradr_i = AW'($urandom);
      pipe_wrdat_i = $urandom;
      pipe_rden_i  = noise;
      pipe_rdad_i  = AW'($urandom);
      #1;
      chk("clr_wren", rf_wren_o, 1'b1);
      chk("clr_wrad", rf_wrad_o, 64'(i));
      chk("clr_wrda", rf_wrda_o, '0);
      chk("clr_rden", rf_rden_o, 1'b0);
      chk("clr_stall", pipe_stall_o, 1'b1);
      chk("clr_init_done", init_done_o, 1'b0);
      chk("clr_ack", dbg_ack_o, 1'b0);
      chk("clr_drop", pipe_drop_o, exp_drop);
      if (pipe_we_i) exp_drop = 1'b1;
    end
    for (int i = 0; i < WORDS; i++) shadow[i] = '0;
  endtask

  task automatic dbg_op(input logic we, input logic [AW-1:0] adr, input logic [DW-1:0] dat,
                        input logic npw, input logic [AW-1:0] npa, input logic [DW-1:0] npd,
                        input logic rnd, input logic acc_pwe);
    logic          pw1;
    logic [AW-1:0] pa1;
    logic [DW-1:0] pd1;
    logic [AW-1:0] ra;
    // request cycle N
    @(negedge clk);
    dbg_req_i    = 1'b1;
    dbg_we_i     = we;
    dbg_adr_i    = adr;
    dbg_dat_i    = dat;
    pipe_we_i    = npw;
    pipe_wradr_i = npa;
    pipe_wrdat_i = npd;
    ra           = AW'($urandom);
    pipe_rden_i  = 1'b1;
    pipe_rdad_i  = ra;
    #1;
    chk("req_stall", pipe_stall_o, 1'b0);
    chk("req_init_done", init_done_o, 1'b1);
    chk("req_wren", rf_wren_o, npw);
    chk("req_wrad", rf_wrad_o, npa);
    chk("req_wrda", rf_wrda_o, npd);
    chk("req_rden", rf_rden_o, 1'b1);
    chk("req_rdad", rf_rdad_o, ra);
    if (npw) shadow[npa] = npd;
    // N+1: in-flight writeback still lands
    @(negedge clk);
    dbg_req_i    = 1'($urandom);
    dbg_we_i     = 1'($urandom);
    dbg_adr_i    = AW'($urandom);
    dbg_dat_i    = $urandom;
    pw1          = rnd & 1'($urandom);
    pa1          = AW'($urandom);
    pd1          = $urandom;
    pipe_we_i    = pw1;
    pipe_wradr_i = pa1;
    pipe_wrdat_i = pd1;
    pipe_rden_i  = 1'b0;
    #1;
    chk("stl_stall", pipe_stall_o, 1'b1);
    chk("stl_wren", rf_wren_o, pw1);
    if (pw1) begin
      chk("stl_wrad", rf_wrad_o, pa1);
      chk("stl_wrda", rf_wrda_o, pd1);
      shadow[pa1] = pd1;
    end
    // N+2: debug owns the RF
    @(negedge clk);
    pipe_we_i    = acc_pwe;
    pipe_wradr_i = AW'($urandom);
    pipe_wrdat_i = $urandom;
    pipe_rden_i  = 1'b1;
    pipe_rdad_i  = AW'($urandom);
    #1;
    chk("acc_stall", pipe_stall_o, 1'b1);
    chk("acc_wren", rf_wren_o, we);
    chk("acc_rden", rf_rden_o, !we);
    if (we) begin
      chk("acc_wrad", rf_wrad_o, adr);
      chk("acc_wrda", rf_wrda_o, dat);
      shadow[adr] = dat;
    end else begin
      chk("acc_rdad", rf_rdad_o, adr);
      exp_dbg_dat = shadow[adr];
    end
    if (acc_pwe) exp_drop = 1'b1;
    // N+3: capture
    @(negedge clk);
    pipe_we_i   = 1'b0;
    pipe_rden_i = 1'b0;
    dbg_req_i   = 1'($urandom);
    #1;
    chk("cap_stall", pipe_stall_o, 1'b1);
    chk("cap_wren", rf_wren_o, 1'b0);
    chk("cap_rden", rf_rden_o, 1'b0);
    chk("cap_ack", dbg_ack_o, 1'b0);
    // N+4: ack
    @(negedge clk);
    idle_inputs();
    #1;
    chk("ack_pulse", dbg_ack_o, 1'b1);
    chk("ack_stall", pipe_stall_o, 1'b0);
    chk("ack_dat", dbg_dat_o, exp_dbg_dat);
    chk("ack_drop", pipe_drop_o, exp_drop);
    // N+5: ack gone, data held
    @(negedge clk);
    #1;
    chk("post_ack", dbg_ack_o, 1'b0);
    chk("post_dat", dbg_dat_o, exp_dbg_dat);
    chk("post_stall", pipe_stall_o, 1'b0);
  endtask

  initial begin
    idle_inputs();
    rst         = 1'b1;
    exp_drop    = 1'b0;
    exp_dbg_dat = '0;
    pipe_we_i   = 1'b1;
    pipe_rden_i = 1'b1;
    dbg_req_i   = 1'b1;
    repeat (3) begin
      @(negedge clk);
      #1;
      chk("rst_stall", pipe_stall_o, 1'b1);
      chk("rst_wren", rf_wren_o, 1'b0);
      chk("rst_rden", rf_rden_o, 1'b0);
      chk("rst_init_done", init_done_o, 1'b0);
      chk("rst_ack", dbg_ack_o, 1'b0);
      chk("rst_drop", pipe_drop_o, 1'b0);
      chk("rst_dbg_dat", dbg_dat_o, '0);
    end
    idle_inputs();
    do_clear(1'b0, 1'b0, '0, '0, 1'b0);

    // cycle 33: plain pass-through write
    @(negedge clk);
    idle_inputs();
    pipe_we_i    = 1'b1;
    pipe_wradr_i = AW'(5);
    pipe_wrdat_i = 32'hDEADBEEF;
    #1;
    chk("idle_init_done", init_done_o, 1'b1);
    chk("idle_stall", pipe_stall_o, 1'b0);
    chk("idle_wren", rf_wren_o, 1'b1);
    chk("idle_wrad", rf_wrad_o, 5);
    chk("idle_wrda", rf_wrda_o, 32'hDEADBEEF);
    shadow[5] = 32'hDEADBEEF;

    dbg_op(1'b1, AW'(7), 32'h12345678, 1'b1, AW'(3), 32'hCAFEF00D, 1'b0, 1'b0);
    dbg_op(1'b0, AW'(7), 32'h0, 1'b0, '0, '0, 1'b0, 1'b0);
    chk("r7_value", dbg_dat_o, 32'h12345678);
    dbg_op(1'b0, AW'(5), 32'h0, 1'b0, '0, '0, 1'b0, 1'b0);
    chk("r5_value", dbg_dat_o, 32'hDEADBEEF);
    chk("drop_clean", pipe_drop_o, 1'b0);
    dbg_op(1'b1, AW'(2), $urandom, 1'b0, '0, '0, 1'b0, 1'b1);
    chk("drop_set", pipe_drop_o, 1'b1);

    for (int k = 0; k < 16; k++) begin
      dbg_op(1'($urandom), AW'($urandom), $urandom, 1'($urandom), AW'($urandom), $urandom,
             1'b1, 1'($urandom));
    end
    @(negedge clk);
    #1;
    for (int i = 0; i < WORDS; i++) chk("ram_contents", mem[i], shadow[i]);

    // reset while the debug unit owns the RF
    @(negedge clk);
    idle_inputs();
    dbg_req_i = 1'b1;
    dbg_we_i  = 1'b1;
    dbg_adr_i = AW'(11);
    dbg_dat_i = $urandom;
    #1;
    chk("ra_req_stall", pipe_stall_o, 1'b0);
    @(negedge clk);
    dbg_req_i = 1'b0;
    #1;
    chk("ra_stl_stall", pipe_stall_o, 1'b1);
    @(negedge clk);
    #1;
    chk("ra_acc_wren", rf_wren_o, 1'b1);
    chk("ra_acc_wrad", rf_wrad_o, 11);
    rst = 1'b1;
    #1;
    chk("ra_rst_wren", rf_wren_o, 1'b0);
    chk("ra_rst_stall", pipe_stall_o, 1'b1);
    chk("ra_rst_init_done", init_done_o, 1'b0);
    exp_drop    = 1'b0;
    exp_dbg_dat = '0;

    // request held through CLEAR starts on the first IDLE cycle
    hold_dat = $urandom;
    do_clear(1'b1, 1'b1, AW'(9), hold_dat, 1'b0);
    dbg_op(1'b1, AW'(9), hold_dat, 1'b0, '0, '0, 1'b0, 1'b0);
    dbg_op(1'b0, AW'(9), 32'h0, 1'b0, '0, '0, 1'b0, 1'b0);
    chk("r9_value", dbg_dat_o, hold_dat);
    dbg_op(1'b0, AW'(11), 32'h0, 1'b0, '0, '0, 1'b0, 1'b0);
    chk("r11_aborted", dbg_dat_o, 32'h0);

    // pipeline writes during CLEAR are dropped and flagged
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst2_stall", pipe_stall_o, 1'b1);
    exp_drop    = 1'b0;
    exp_dbg_dat = '0;
    do_clear(1'b0, 1'b0, '0, '0, 1'b1);
    @(negedge clk);
    idle_inputs();
    #1;
    chk("final_init_done", init_done_o, 1'b1);
    chk("final_stall", pipe_stall_o, 1'b0);
    chk("final_drop", pipe_drop_o, 1'b1);
    chk("final_dbg_dat", dbg_dat_o, '0);
    for (int i = 0; i < WORDS; i++) chk("ram_cleared", mem[i], shadow[i]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
